// File: rtl/level_sequencer_pkg.sv
// Shared types and constants for the level sequencer: FSM state encoding,
// level range, and datapath widths.
package level_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_PLAY    = 3'd2,
    S_ADVANCE = 3'd3,
    S_WIN     = 3'd4,
    S_LOSE    = 3'd5
  } state_t;

  localparam int LEVEL_W = 3;
  localparam int SCORE_W = 8;

  localparam logic [LEVEL_W-1:0] MIN_LEVEL = 3'd1;
  localparam logic [LEVEL_W-1:0] MAX_LEVEL = 3'd5;

  // Score sticks at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/level_sequencer_tick_gen.sv
// Prescaler: while clr is low, emits a one-cycle registered tick on the
// TICK_DIV-th cycle after clr drops, then every TICK_DIV cycles.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Tick is registered, so it is raised one count early to land on the
  // TICK_DIV-th cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      r_tick <= (r_cnt == PRE);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/level_sequencer.sv
// Game level sequencer: walks levels 1..5 on player hits, spends lives on
// timeouts, and drives enable/clear/tick to the external level counter.
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int TICK_DIV       = 50000000,
  parameter int HITS_PER_LEVEL = 4,
  parameter int LIVES          = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  input  logic               timeout,
  output logic [LEVEL_W-1:0] cur_level,
  output logic               cnt_enable,
  output logic               cnt_tick,
  output logic               cnt_rst_n,
  output logic [1:0]         lives_left,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               win,
  output state_t             dbg_state
);

  localparam logic [3:0] HITS_LAST  = 4'(HITS_PER_LEVEL - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t             r_state;
  logic [LEVEL_W-1:0] r_level;
  logic [SCORE_W-1:0] r_score;
  logic [1:0]         r_lives;
  logic [3:0]         r_hits;
  logic               r_en;
  logic               r_rst_n;
  logic               r_game_over;
  logic               r_win;

  logic w_play_exit;
  logic w_clr;
  logic w_tick;

  // Prescaler runs only while PLAY continues into the next cycle, so its
  // registered tick can never show up outside PLAY.
  assign w_play_exit = hit ? (r_hits == HITS_LAST) : timeout;
  assign w_clr       = (r_state != S_PLAY) || w_play_exit;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_level     <= MIN_LEVEL;
      r_score     <= '0;
      r_lives     <= '0;
      r_hits      <= '0;
      r_en        <= 1'b0;
      r_rst_n     <= 1'b0;
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            r_state     <= S_ARM;
            r_level     <= MIN_LEVEL;
            r_score     <= '0;
            r_lives     <= LIVES_INIT;
            r_hits      <= '0;
            r_en        <= 1'b0;
            r_rst_n     <= 1'b0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
          end
        end
        S_ARM: begin
          r_state <= S_PLAY;
          r_en    <= 1'b1;
          r_rst_n <= 1'b1;
        end
        S_PLAY: begin
          // A simultaneous timeout is dropped in favour of the hit.
          if (hit) begin
            r_score <= sat_inc(r_score);
            r_hits  <= r_hits + 4'd1;
            if (r_hits == HITS_LAST) begin
              r_en    <= 1'b0;
              r_rst_n <= 1'b0;
              if (r_level == MAX_LEVEL) begin
                r_state     <= S_WIN;
                r_game_over <= 1'b1;
                r_win       <= 1'b1;
              end else begin
                r_state <= S_ADVANCE;
              end
            end
          end else if (timeout) begin
            r_lives <= r_lives - 2'd1;
            r_en    <= 1'b0;
            r_rst_n <= 1'b0;
            if (r_lives == 2'd1) begin
              r_state     <= S_LOSE;
              r_game_over <= 1'b1;
            end else begin
              r_state <= S_ARM;
            end
          end
        end
        S_ADVANCE: begin
          if (r_level < MAX_LEVEL) r_level <= r_level + 3'd1;
          r_hits  <= '0;
          r_state <= S_ARM;
        end
        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
          r_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign cur_level  = r_level;
  assign cnt_enable = r_en;
  assign cnt_tick   = w_tick;
  assign cnt_rst_n  = r_rst_n;
  assign lives_left = r_lives;
  assign score      = r_score;
  assign game_over  = r_game_over;
  assign win        = r_win;
  assign dbg_state  = r_state;

endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per counter tick (>=2).
REQ-002 SHALL have parameter HITS_PER_LEVEL, default 4, hits required to clear one level (1..15).
REQ-003 SHALL have parameter LIVES, default 3, lives per game (1..3).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that starts a new game.
REQ-007 SHALL have port hit, input, 1, single-cycle pulse for a correct player hit.
REQ-008 SHALL have port timeout, input, 1, single-cycle pulse from the level timeout counter.
REQ-009 SHALL have port cur_level, output, 3, current level 1..5, driven to the counter.
REQ-010 SHALL have port cnt_enable, output, 1, counter enable.
REQ-011 SHALL have port cnt_tick, output, 1, one-cycle count pulse to the counter.
REQ-012 SHALL have port cnt_rst_n, output, 1, active-low synchronous clear to the counter.
REQ-013 SHALL have port lives_left, output, 2, remaining lives.
REQ-014 SHALL have port score, output, 8, total hits this game, saturating.
REQ-015 SHALL have port game_over, output, 1, high while in WIN or LOSE.
REQ-016 SHALL have port win, output, 1, high only while in WIN.

Function
REQ-017 SHALL implement states IDLE, ARM, PLAY, ADVANCE, WIN, LOSE, all registered.
REQ-018 IDLE: cnt_enable=0, cnt_rst_n=0. A start pulse SHALL load cur_level=1, score=0, lives_left=LIVES, hit count=0, and go to ARM.
REQ-019 ARM SHALL last exactly one cycle with cnt_rst_n=0, cnt_enable=0, prescaler cleared, and SHALL then go to PLAY.
REQ-020 PLAY SHALL drive cnt_enable=1 and cnt_rst_n=1. cnt_tick SHALL pulse for one cycle on the TICK_DIV-th cycle after PLAY entry, then every TICK_DIV cycles.
REQ-021 A hit in PLAY SHALL increment score (saturating at 255) and the hit count. When the hit count reaches HITS_PER_LEVEL, the next state SHALL be WIN if cur_level=5, else ADVANCE.
REQ-022 A timeout in PLAY without a hit SHALL decrement lives_left. The next state SHALL be LOSE if the new value is 0, else ARM (same level, hit count kept).
REQ-023 A hit and a timeout in the same cycle SHALL be treated as a hit only; the timeout is discarded.
REQ-024 ADVANCE SHALL last one cycle, increment cur_level, clear the hit count, and go to ARM.
REQ-025 WIN/LOSE SHALL hold cur_level, score and lives_left, with cnt_enable=0 and cnt_rst_n=0. A start pulse SHALL begin a fresh game exactly as in REQ-018.
REQ-026 start SHALL be ignored in ARM, PLAY and ADVANCE. hit and timeout SHALL be ignored outside PLAY.
REQ-027 cur_level SHALL never leave the range 1..5. cnt_tick SHALL be 0 in every state except PLAY.
REQ-028 All outputs SHALL be registered, with one-cycle latency from input event to output change.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, cur_level=1, cnt_enable=0, cnt_tick=0, cnt_rst_n=0, lives_left=0, score=0, game_over=0, win=0, hit count=0, prescaler=0.
REQ-030 rst SHALL take priority over start, hit and timeout in the same cycle, including mid-PLAY.

Structure
REQ-031 A shared package SHALL hold the state enum, MIN_LEVEL=1, MAX_LEVEL=5, the level width (3) and the score width (8).
REQ-032 The prescaler SHALL be a sub-module tick_gen (inputs clk, rst, clr; output tick) instantiated once.

Verification (TICK_DIV=4, HITS_PER_LEVEL=2, LIVES=2)
REQ-033 Reset, then start -> ARM one cycle with cnt_rst_n=0, then PLAY; first cnt_tick 4 cycles after PLAY entry; cur_level=1, lives_left=2.
REQ-034 Ten hits spaced 3 cycles apart -> cur_level steps 1,2,3,4,5; after the tenth hit win=1, game_over=1, score=10.
REQ-035 Two timeouts at level 1 -> lives_left 2->1 (via ARM) ->0; LOSE with game_over=1, win=0.
REQ-036 hit and timeout asserted in the same PLAY cycle -> score+1, lives_left unchanged.
REQ-037 rst asserted mid-PLAY at level 3 -> next cycle IDLE, all outputs at reset values; start during PLAY -> no effect.
